bnn_sample_sequencer: RTL and testbench

Upstream driver for the sequential BNN classifier (e.g. `winered_bnn1_bnnromex`). It accepts one quantized feature per valid/ready beat, packs a full `FEAT_CNT`-feature sample, and pulses the classifier's reset. It then waits the classifier's fixed compute latency, captures `prediction`, and returns the class on a valid/ready output with a framing/range error flag. It replaces the ad-hoc reset/wait sequencing currently done in benches, so the classifier can be fed from a real stream.

---
 rtl/bnn_seq_pkg.sv | 24 ++
 rtl/bnn_feat_packer.sv | 54 +++++
 rtl/bnn_sample_sequencer.sv | 136 +++++++++++++
 tb/tb_bnn_sample_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_seq_pkg.sv
// Shared definitions for the BNN sample sequencer: state encoding and the
// width/latency derivations reused by benches and classifier-side wrappers.
package bnn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_KICK  = 3'd3,
    ST_RUN   = 3'd4,
    ST_OUT   = 3'd5
  } seq_state_t;

  // Width of a class index; a single-class classifier still needs one bit.
  function automatic int cls_bits(input int class_cnt);
    return (class_cnt <= 1) ? 1 : $clog2(class_cnt);
  endfunction

  // Fixed compute latency of the sequential classifier, in clock cycles.
  function automatic int wait_cycles(input int hidden_cnt, input int class_cnt);
    return hidden_cnt + class_cnt + 1;
  endfunction

endpackage

// File: rtl/bnn_feat_packer.sv
// Beat counter plus insert register: places each accepted feature into the
// next lower slot so the first beat ends up in the most significant nibble.
module bnn_feat_packer
  import bnn_seq_pkg::*;
#(
  parameter int FEAT_CNT  = 11,
  parameter int FEAT_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          load,
  input  logic [FEAT_BITS-1:0]          data,
  output logic                          full,
  output logic [FEAT_BITS*FEAT_CNT-1:0] word
);

  localparam int IDX_BITS = (FEAT_CNT <= 1) ? 1 : $clog2(FEAT_CNT);

  logic [IDX_BITS-1:0]           idx_r;
  logic [FEAT_BITS*FEAT_CNT-1:0] word_r;

  // Accepted-beat index, restarted whenever the sequencer re-enters LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= '0;
    end else if (clr) begin
      idx_r <= '0;
    end else if (load) begin
      idx_r <= idx_r + IDX_BITS'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Insert the beat at the slot selected by the current index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_r <= '0;
    end else if (load) begin
      for (int i = 0; i < FEAT_CNT; i++) begin
        if (idx_r == IDX_BITS'(i)) begin
          word_r[(FEAT_CNT-1-i)*FEAT_BITS +: FEAT_BITS] <= data;
        end
      end
    end else begin
      word_r <= word_r;
    end
  end

  assign full = (idx_r == IDX_BITS'(FEAT_CNT - 1));
  assign word = word_r;

endmodule

// File: rtl/bnn_sample_sequencer.sv
// Streams one sample into the sequential BNN classifier, pulses its reset,
// waits out its compute latency and returns the class with an error flag.
module bnn_sample_sequencer
  import bnn_seq_pkg::*;
#(
  parameter  int FEAT_CNT   = 11,
  parameter  int FEAT_BITS  = 4,
  parameter  int HIDDEN_CNT = 40,
  parameter  int CLASS_CNT  = 6,
  localparam int CLS_BITS   = cls_bits(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_last,
  output logic [FEAT_BITS*FEAT_CNT-1:0] bnn_features,
  output logic                          bnn_rst,
  input  logic [CLS_BITS-1:0]           bnn_prediction,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CLS_BITS-1:0]           m_class,
  output logic                          m_err
);

  localparam int W       = wait_cycles(HIDDEN_CNT, CLASS_CNT);
  localparam int WC_BITS = $clog2(W + 1);

  seq_state_t         state_r;
  logic [WC_BITS-1:0] wait_cnt_r;
  logic               load_beat_s;
  logic               drain_beat_s;
  logic               clr_s;
  logic               full_s;

  assign load_beat_s  = s_valid & s_ready & (state_r == ST_LOAD);
  assign drain_beat_s = s_valid & s_ready & (state_r == ST_DRAIN);
  assign clr_s        = (state_r == ST_IDLE) | ((state_r == ST_OUT) & m_ready);

  bnn_feat_packer #(
    .FEAT_CNT  (FEAT_CNT),
    .FEAT_BITS (FEAT_BITS)
  ) u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .load (load_beat_s),
    .data (s_data),
    .full (full_s),
    .word (bnn_features)
  );

  // Sequencer FSM; every output is registered alongside the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      m_err      <= 1'b0;
      bnn_rst    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_LOAD;
          s_ready <= 1'b1;
          bnn_rst <= 1'b1;
        end
        ST_LOAD: begin
          if (load_beat_s && s_last && full_s) begin
            state_r <= ST_KICK;
            s_ready <= 1'b0;
          end else if (load_beat_s && s_last) begin
            state_r <= ST_OUT;
            s_ready <= 1'b0;
            m_valid <= 1'b1;
            m_class <= '0;
            m_err   <= 1'b1;
          end else if (load_beat_s && full_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_beat_s && s_last) begin
            state_r <= ST_OUT;
            s_ready <= 1'b0;
            m_valid <= 1'b1;
            m_class <= '0;
            m_err   <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_KICK: begin
          state_r    <= ST_RUN;
          bnn_rst    <= 1'b0;
          wait_cnt_r <= '0;
        end
        ST_RUN: begin
          if (wait_cnt_r == WC_BITS'(W - 1)) begin
            state_r <= ST_OUT;
            bnn_rst <= 1'b1;
            m_valid <= 1'b1;
            m_class <= bnn_prediction;
            m_err   <= (bnn_prediction > CLS_BITS'(CLASS_CNT - 1));
          end else begin
            wait_cnt_r <= wait_cnt_r + WC_BITS'(1);
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            state_r <= ST_LOAD;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= '0;
          s_ready    <= 1'b0;
          m_valid    <= 1'b0;
          m_class    <= '0;
          m_err      <= 1'b0;
          bnn_rst    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_sample_sequencer.sv
// Directed bench for bnn_sample_sequencer with a behavioural classifier that
// simply presents a chosen prediction value.
module tb_bnn_sample_sequencer;

  localparam int FEAT_CNT  = 11;
  localparam int FEAT_BITS = 4;
  localparam int CLS_BITS  = 3;
  localparam int W         = 47;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic                          s_valid = 1'b0;
  logic                          s_ready;
  logic [FEAT_BITS-1:0]          s_data = 4'h0;
  logic                          s_last = 1'b0;
  logic [FEAT_BITS*FEAT_CNT-1:0] bnn_features;
  logic                          bnn_rst;
  logic [CLS_BITS-1:0]           pred = 3'd0;
  logic                          m_valid;
  logic                          m_ready = 1'b0;
  logic [CLS_BITS-1:0]           m_class;
  logic                          m_err;

  int n_chk  = 0;
  int n_pass = 0;

  bnn_sample_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .bnn_features   (bnn_features),
    .bnn_rst        (bnn_rst),
    .bnn_prediction (pred),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_class        (m_class),
    .m_err          (m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat i carries start + i*step; s_last on the n-th beat.
  task automatic send_frame(input int n, input int start, input int step);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 4'(start + i * step);
      s_last  = (i == n - 1);
      guard   = 0;
      while (!s_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) chk("beat_ready_timeout", 64'd0, 64'd1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Edges from the last accepted beat until m_valid, and RUN cycles seen.
  task automatic wait_result(output int lat, output int low_cnt, output logic [43:0] feat_run);
    lat = 0;
    low_cnt = 0;
    feat_run = '0;
    while (!m_valid && lat < 300) begin
      if (!bnn_rst) begin
        if (low_cnt == 0) feat_run = bnn_features;
        low_cnt++;
      end
      tick();
      lat++;
    end
  endtask

  task automatic take_result();
    chk("take_m_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("after_hs_m_valid", 64'(m_valid), 64'd0);
    chk("after_hs_s_ready", 64'(s_ready), 64'd1);
  endtask

  initial begin
    int          lat;
    int          low;
    logic [43:0] feat;
    logic        bp_ok;
    logic [2:0]  held_cls;
    int          t[3];
    int          k;
    int          b;
    logic        acc;

    // Reset values while rst is held low
    repeat (2) @(posedge clk);
    #3;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_class", 64'(m_class), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_bnn_rst", 64'(bnn_rst), 64'd1);
    chk("rst_features", 64'(bnn_features), 64'd0);
    rst = 1'b1;
    chk("idle_s_ready", 64'(s_ready), 64'd0);
    tick();
    chk("load_s_ready", 64'(s_ready), 64'd1);
    chk("load_bnn_rst", 64'(bnn_rst), 64'd1);

    // Single good frame 1..B, classifier says 3
    pred = 3'd3;
    send_frame(11, 1, 1);
    chk("kick_bnn_rst", 64'(bnn_rst), 64'd1);
    chk("kick_s_ready", 64'(s_ready), 64'd0);
    chk("kick_features", 64'(bnn_features), 64'h123456789AB);
    wait_result(lat, low, feat);
    chk("good_latency", 64'(lat), 64'(W + 1));
    chk("good_run_cycles", 64'(low), 64'(W));
    chk("good_run_features", 64'(feat), 64'h123456789AB);
    chk("good_class", 64'(m_class), 64'd3);
    chk("good_err", 64'(m_err), 64'd0);
    chk("good_out_bnn_rst", 64'(bnn_rst), 64'd1);
    take_result();

    // Short frame: s_last on beat 5
    send_frame(5, 1, 1);
    wait_result(lat, low, feat);
    chk("short_latency", 64'(lat), 64'd0);
    chk("short_run_cycles", 64'(low), 64'd0);
    chk("short_class", 64'(m_class), 64'd0);
    chk("short_err", 64'(m_err), 64'd1);
    take_result();

    // Long frame: 14 beats F,E,...,2; beats 12-14 discarded
    send_frame(14, 15, -1);
    wait_result(lat, low, feat);
    chk("long_latency", 64'(lat), 64'd0);
    chk("long_run_cycles", 64'(low), 64'd0);
    chk("long_class", 64'(m_class), 64'd0);
    chk("long_err", 64'(m_err), 64'd1);
    chk("long_features", 64'(bnn_features), 64'hFEDCBA98765);
    take_result();

    // Recovery frame, then back-pressure on the result
    pred = 3'd4;
    send_frame(11, 1, 1);
    wait_result(lat, low, feat);
    chk("recov_latency", 64'(lat), 64'(W + 1));
    chk("recov_class", 64'(m_class), 64'd4);
    chk("recov_err", 64'(m_err), 64'd0);
    bp_ok = 1'b1;
    held_cls = m_class;
    s_valid = 1'b1;
    s_data = 4'hF;
    s_last = 1'b1;
    pred = 3'd1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!m_valid || m_class != held_cls || m_err || s_ready) bp_ok = 1'b0;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("bp_stable", 64'(bp_ok), 64'd1);
    chk("bp_class", 64'(m_class), 64'd4);
    chk("bp_features", 64'(bnn_features), 64'h123456789AB);
    take_result();

    // Back-to-back frames with s_valid and m_ready tied high
    pred = 3'd3;
    m_ready = 1'b1;
    s_valid = 1'b1;
    b = 0;
    s_data = 4'h1;
    s_last = 1'b0;
    k = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    for (int c = 0; c < 250 && k < 3; c++) begin
      if (m_valid) begin
        t[k] = c;
        k++;
        chk("stream_class", 64'(m_class), 64'd3);
      end
      acc = s_ready;
      tick();
      if (acc) begin
        b = (b == 10) ? 0 : b + 1;
        s_data = 4'(b + 1);
        s_last = (b == 10);
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b0;
    chk("stream_results", 64'(k), 64'd3);
    chk("stream_period_a", 64'(t[1] - t[0]), 64'd60);
    chk("stream_period_b", 64'(t[2] - t[1]), 64'd60);

    // Out-of-range prediction
    pred = 3'd7;
    send_frame(11, 1, 1);
    wait_result(lat, low, feat);
    chk("oor_class", 64'(m_class), 64'd7);
    chk("oor_err", 64'(m_err), 64'd1);
    take_result();

    // Reset asserted during RUN cycle 20
    pred = 3'd2;
    send_frame(11, 1, 1);
    repeat (20) tick();
    chk("mid_run_bnn_rst", 64'(bnn_rst), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_s_ready", 64'(s_ready), 64'd0);
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_m_class", 64'(m_class), 64'd0);
    chk("arst_m_err", 64'(m_err), 64'd0);
    chk("arst_bnn_rst", 64'(bnn_rst), 64'd1);
    chk("arst_features", 64'(bnn_features), 64'd0);
    #3 rst = 1'b1;
    chk("rel_s_ready_idle", 64'(s_ready), 64'd0);
    tick();
    chk("rel_s_ready_load", 64'(s_ready), 64'd1);
    send_frame(11, 1, 1);
    wait_result(lat, low, feat);
    chk("fresh_latency", 64'(lat), 64'(W + 1));
    chk("fresh_class", 64'(m_class), 64'd2);
    chk("fresh_err", 64'(m_err), 64'd0);
    take_result();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
